// File: rtl/ram_pkg.sv
// Shared helpers for the RAM primitives.
//
// safeAddrWidth(size) returns the address width needed to index `size`
// words, never less than one bit, so a port stays declarable even for
// degenerate sizes.
package ram_pkg;

  function automatic int safeAddrWidth(input int size);
    int w;
    w = $clog2(size);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ram_1r_1w.sv
// ram_1r_1w: simple dual-port RAM, one synchronous write port and one
// synchronous registered read port on a single clock. The storage array is
// not reset (block-RAM friendly); only the read-data register is.
//
// Parameters:
//   DEPTH  data word width in bits
//   SIZE   number of words; address width AW = max(1, $clog2(SIZE))
//
// Ports:
//   aClock         clock, rising edge active
//   aReset         asynchronous active-high reset; clears anOutReadData
//   aReadAddress   read word index
//   anOutReadData  registered read data (1-cycle latency)
//   aReadEnable    read strobe; when low the output holds
//   aWriteAddress  write word index
//   aWriteData     write data
//   aWriteEnable   write strobe
//
// Build option:
//   RAM_1R_1W_WRITE_THROUGH_EN  when defined, a same-cycle read and write to
//   the same in-range address returns the new write data (write-first).
//   When undefined the read returns the old contents (read-first) and no
//   address-compare logic exists.
//
// Out-of-range addresses (only possible when SIZE is not a power of two):
// writes are dropped and reads load zero.
module ram_1r_1w
  import ram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int SIZE  = 64,
  localparam int AW   = safeAddrWidth(SIZE)
) (
  input  logic             aClock,
  input  logic             aReset,
  input  logic [AW-1:0]    aReadAddress,
  output logic [DEPTH-1:0] anOutReadData,
  input  logic             aReadEnable,
  input  logic [AW-1:0]    aWriteAddress,
  input  logic [DEPTH-1:0] aWriteData,
  input  logic             aWriteEnable
);

  logic [DEPTH-1:0] mem [SIZE];
  logic [DEPTH-1:0] readData;
  logic [DEPTH-1:0] readValue;
  logic             readInRange;
  logic             writeInRange;

  // When SIZE fills the address space every address is valid, so no
  // comparator is built at all.
  if (SIZE == (1 << AW)) begin : gFullRange
    assign readInRange  = 1'b1;
    assign writeInRange = 1'b1;
  end else begin : gPartialRange
    localparam logic [AW:0] WORDS = (AW + 1)'(SIZE);
    assign readInRange  = ({1'b0, aReadAddress}  < WORDS);
    assign writeInRange = ({1'b0, aWriteAddress} < WORDS);
  end

  // Value presented to the read register this cycle.
  always_comb begin
    readValue = '0;
    if (readInRange) begin
      readValue = mem[aReadAddress];
`ifdef RAM_1R_1W_WRITE_THROUGH_EN
      // Write-first bypass on a same-address collision.
      if (aWriteEnable && writeInRange && (aWriteAddress == aReadAddress)) begin
        readValue = aWriteData;
      end
`endif
    end
  end

  // Storage array: no reset so it maps to block RAM. Writes are suppressed
  // while reset is held.
  always_ff @(posedge aClock) begin
    if (!aReset && aWriteEnable && writeInRange) begin
      mem[aWriteAddress] <= aWriteData;
    end
  end

  // Read register: cleared asynchronously, holds when the strobe is low.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      readData <= '0;
    end else if (aReadEnable) begin
      readData <= readValue;
    end
  end

  assign anOutReadData = readData;

endmodule

// File: tb/tb_ram_1r_1w.sv
// Testbench for ram_1r_1w. Two instances: the default 64 x 64 RAM and a
// 48-word x 16-bit RAM that exercises out-of-range addressing. Expected
// read data comes from a plain array model of the memory contents.
module tb_ram_1r_1w;

  // ---------------- clock / reset ----------------
  logic aClock;
  logic aReset;
  logic aReset48;

  initial aClock = 1'b0;
  always #5 aClock = ~aClock;

  // ---------------- 64 x 64 instance ----------------
  logic [5:0]  aReadAddress;
  logic [63:0] anOutReadData;
  logic        aReadEnable;
  logic [5:0]  aWriteAddress;
  logic [63:0] aWriteData;
  logic        aWriteEnable;

  ram_1r_1w #(.DEPTH(64), .SIZE(64)) dut (
    .aClock        (aClock),
    .aReset        (aReset),
    .aReadAddress  (aReadAddress),
    .anOutReadData (anOutReadData),
    .aReadEnable   (aReadEnable),
    .aWriteAddress (aWriteAddress),
    .aWriteData    (aWriteData),
    .aWriteEnable  (aWriteEnable)
  );

  // ---------------- 48 x 16 instance ----------------
  logic [5:0]  rdAddr48;
  logic [15:0] rdData48;
  logic        rdEn48;
  logic [5:0]  wrAddr48;
  logic [15:0] wrData48;
  logic        wrEn48;

  ram_1r_1w #(.DEPTH(16), .SIZE(48)) dut48 (
    .aClock        (aClock),
    .aReset        (aReset48),
    .aReadAddress  (rdAddr48),
    .anOutReadData (rdData48),
    .aReadEnable   (rdEn48),
    .aWriteAddress (wrAddr48),
    .aWriteData    (wrData48),
    .aWriteEnable  (wrEn48)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] model64 [64];
  logic [15:0] model48 [48];
  logic [63:0] exp64;
  logic [15:0] exp48;
  int compared;
  int mismatched;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock of the 64-word RAM: drive, predict, clock, check.
  task automatic cycle64(input logic we, input int wa, input logic [63:0] wd,
                         input logic re, input int ra, input string tag);
    aWriteEnable  = we;
    aWriteAddress = 6'(wa);
    aWriteData    = wd;
    aReadEnable   = re;
    aReadAddress  = 6'(ra);
    if (re) begin
      exp64 = model64[ra];
`ifdef RAM_1R_1W_WRITE_THROUGH_EN
      if (we && (wa == ra)) exp64 = wd;
`endif
    end
    if (we) model64[wa] = wd;
    @(posedge aClock);
    #1;
    check(tag, anOutReadData, exp64);
    aWriteEnable = 1'b0;
    aReadEnable  = 1'b0;
  endtask

  // One clock of the 48-word RAM; addresses 48..63 are out of range.
  task automatic cycle48(input logic we, input int wa, input logic [15:0] wd,
                         input logic re, input int ra, input string tag);
    wrEn48   = we;
    wrAddr48 = 6'(wa);
    wrData48 = wd;
    rdEn48   = re;
    rdAddr48 = 6'(ra);
    if (re) begin
      exp48 = (ra < 48) ? model48[ra] : 16'h0;
`ifdef RAM_1R_1W_WRITE_THROUGH_EN
      if (we && (wa == ra) && (wa < 48)) exp48 = wd;
`endif
    end
    if (we && (wa < 48)) model48[wa] = wd;
    @(posedge aClock);
    #1;
    check(tag, {48'h0, rdData48}, {48'h0, exp48});
    wrEn48 = 1'b0;
    rdEn48 = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    compared     = 0;
    mismatched   = 0;
    exp64        = '0;
    exp48        = '0;
    aReset       = 1'b1;
    aReset48     = 1'b1;
    aWriteEnable = 1'b0;
    aReadEnable  = 1'b0;
    aWriteAddress = '0;
    aReadAddress  = '0;
    aWriteData    = '0;
    wrEn48   = 1'b0;
    rdEn48   = 1'b0;
    wrAddr48 = '0;
    rdAddr48 = '0;
    wrData48 = '0;

    // Reset state
    repeat (2) @(posedge aClock);
    #1;
    check("reset_out64", anOutReadData, 64'h0);
    check("reset_out48", {48'h0, rdData48}, 64'h0);
    aReset   = 1'b0;
    aReset48 = 1'b0;

    // Write at edge N, visible after edge N+1
    cycle64(1'b1, 5, 64'h1234, 1'b0, 0, "write5_no_read_yet");
    cycle64(1'b0, 0, 64'h0, 1'b1, 5, "read5");
    // Hold with read disabled and a different address
    cycle64(1'b0, 0, 64'h0, 1'b0, 9, "hold_after_read5");

    // Sequential fill and readback
    for (int i = 0; i < 64; i++) cycle64(1'b1, i, 64'(i * 3), 1'b0, 0, "fill");
    for (int i = 0; i < 64; i++) cycle64(1'b0, 0, 64'h0, 1'b1, i, "readback");

    // Same-address collision
    cycle64(1'b1, 7, 64'hAA, 1'b0, 0, "coll_pre");
    cycle64(1'b1, 7, 64'hBB, 1'b1, 7, "coll_same_cycle");
    cycle64(1'b0, 0, 64'h0, 1'b1, 7, "coll_after");

    // Asynchronous reset mid-cycle, write suppressed during reset
    cycle64(1'b1, 10, 64'hDEAD, 1'b0, 0, "rst_pre_write");
    cycle64(1'b0, 0, 64'h0, 1'b1, 10, "rst_pre_read");
    #2;
    aReset = 1'b1;
    #1;
    check("rst_async_clear", anOutReadData, 64'h0);
    aWriteEnable  = 1'b1;
    aWriteAddress = 6'd10;
    aWriteData    = 64'hBEEF;
    aReadEnable   = 1'b1;
    aReadAddress  = 6'd10;
    @(posedge aClock);
    #1;
    check("rst_hold_zero", anOutReadData, 64'h0);
    aWriteEnable = 1'b0;
    aReadEnable  = 1'b0;
    aReset       = 1'b0;
    exp64        = '0;
    cycle64(1'b0, 0, 64'h0, 1'b0, 0, "rst_release_hold");
    cycle64(1'b0, 0, 64'h0, 1'b1, 10, "rst_write_blocked");

    // Random traffic on the 64-word RAM (all locations already written)
    for (int n = 0; n < 300; n++) begin
      cycle64(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 63)), "rand64");
    end

    // 48-word RAM: fill, boundary and out-of-range checks
    for (int i = 0; i < 48; i++) cycle48(1'b1, i, 16'(i * 7 + 1), 1'b0, 0, "fill48");
    cycle48(1'b1, 50, 16'h5555, 1'b0, 0, "oor_write");
    cycle48(1'b0, 0, 16'h0, 1'b1, 47, "read47");
    cycle48(1'b0, 0, 16'h0, 1'b1, 50, "oor_read");
    cycle48(1'b1, 47, 16'hA5A5, 1'b0, 0, "write47");
    cycle48(1'b0, 0, 16'h0, 1'b1, 47, "reread47");
    cycle48(1'b0, 0, 16'h0, 1'b1, 2, "read2_after_oor");
    for (int n = 0; n < 200; n++) begin
      cycle48(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
              16'($urandom), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 63)), "rand48");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_1r_1w.md
Name: ram_1r_1w

Overview:
- Simple dual-port RAM with one synchronous write port and one synchronous registered read port, both on a single clock.
- Generic storage primitive used across the GPU, e.g. as the command buffer cache inside the command fetcher (64 entries x COMMAND_DEPTH bits).
- Maps onto FPGA block RAM: the array is not reset, only the read-data register is.

Parameters:
- DEPTH, 64, data word width in bits (>=1).
- SIZE, 64, number of words (>=2); address width AW = $clog2(SIZE).

Ports:
- aClock  input  1  clock; all activity on the rising edge.
- aReset  input  1  reset, asynchronous, active-high; clears the read-data register.
- aReadAddress  input  AW  read word index.
- anOutReadData  output  DEPTH  registered read data.
- aReadEnable  input  1  read strobe.
- aWriteAddress  input  AW  write word index.
- aWriteData  input  DEPTH  write data.
- aWriteEnable  input  1  write strobe.

Behaviour:
- Interface: one clock, aClock; aReset is asynchronous and active-high.
- Storage: SIZE x DEPTH array; contents undefined after power-up and unaffected by aReset.
- Write: at a rising edge with aWriteEnable=1 and aReset=0, mem[aWriteAddress] <= aWriteData. Data is visible to reads issued from the next edge on.
- Read latency: 1 cycle. At a rising edge with aReadEnable=1, anOutReadData <= mem[aReadAddress].
- Read disabled: with aReadEnable=0, anOutReadData holds its last value.
- Reset: while aReset=1, anOutReadData = 0 immediately (asynchronous), and writes and reads are suppressed. Reset value of anOutReadData is all zeros. Deassertion has no side effects; the next edge operates normally.
- Out-of-range addresses (only possible when SIZE is not a power of 2; address >= SIZE):
  - a write is ignored;
  - a read loads 0 into anOutReadData.
- Same-address read and write in one cycle: read-first by default, so anOutReadData gets the old contents and the new data is stored.
- Different addresses in the same cycle: fully independent, no stall.
- No handshake, no busy signal; every cycle accepts one read and one write.

Optional Feature:
- Macro RAM_1R_1W_WRITE_THROUGH_EN.
- Defined: on a same-cycle read and write to the same in-range address, anOutReadData gets aWriteData (write-first bypass). Implemented as an address-compare mux in front of the read register.
- Undefined: read-first as above; no compare logic is generated.

Decomposition:
- Shared package ram_pkg: function for safe address width (max(1,$clog2(SIZE))).
- The DEPTH/width constants MAIN_MEMORY_BUS_DEPTH and COMMAND_DEPTH stay in the global defines.
- Single module, no sub-module. The bypass mux stays inline under the macro.

Test Plan:
- Reset: assert aReset mid-cycle while anOutReadData=0xDEAD -> output drops to 0 without waiting for a clock edge; a write attempted during reset leaves the location unchanged.
- Write/read: write mem[5]=0x1234 at edge N; read addr 5 at edge N+1 -> anOutReadData=0x1234 after edge N+1, not before.
- Hold: after reading 0x1234, drop aReadEnable and change aReadAddress to 9 -> output stays 0x1234.
- Sequential fill: write addresses 0..63 with value (i*3), then read all back -> each value correct with 1-cycle latency; reads of 0 and 63 correct.
- Collision, default build: mem[7]=0xAA, then same-cycle write 0xBB / read addr 7 -> output 0xAA; next read returns 0xBB. With RAM_1R_1W_WRITE_THROUGH_EN the first read returns 0xBB.
- SIZE=48 build: write addr 50 ignored; read addr 50 -> 0; writes and reads at addr 47 work normally.
